// File: rtl/fnd_pkg.sv
// Shared definitions for the 4-digit 7-segment scan controller:
// watch state encoding, segment lookup and digit-enable patterns.
package fnd_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SET_SEC  = 3'd1;
    localparam logic [2:0] ST_SET_MIN  = 3'd2;
    localparam logic [2:0] ST_SET_HOUR = 3'd3;

    // Segments are active-low, bit order {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Digit enables are active-low, bit0 = ones digit
    localparam logic [3:0] COM_OFF = 4'b1111;
    localparam logic [3:0] COM_D0  = 4'b1110;
    localparam logic [3:0] COM_D1  = 4'b1101;
    localparam logic [3:0] COM_D2  = 4'b1011;
    localparam logic [3:0] COM_D3  = 4'b0111;

    function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
        logic [7:0] seg;
        case (bcd)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [3:0] sel_to_com(input logic [1:0] sel);
        logic [3:0] com;
        case (sel)
            2'd0:    com = COM_D0;
            2'd1:    com = COM_D1;
            2'd2:    com = COM_D2;
            default: com = COM_D3;
        endcase
        return com;
    endfunction

endpackage

// File: rtl/fnd_tick_gen.sv
// Divides the system clock down to a single-cycle scan tick at SCAN_HZ.
// SCAN_DIV = CLK_HZ / SCAN_HZ must be at least 2.
module fnd_tick_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running counter 0..SCAN_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Latches one coherent frame of inputs per scan cycle, saturates to 9999,
// blinks the field under adjustment and flashes the centre dp at 1 Hz.
// Optional build macro: FND_LEADING_ZERO_BLANK_EN (blank a zero thousands digit).
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] i_data,
    input  logic [6:0]  i_msec,
    input  logic [2:0]  i_watch_state,
    input  logic        i_display_switch,
    output logic [3:0]  o_fnd_com,
    output logic [7:0]  o_fnd_data
);

    function automatic logic [13:0] sat_9999(input logic [13:0] v);
        return (v > 14'd9999) ? 14'd9999 : v;
    endfunction

    logic        tick;
    logic [1:0]  sel;
    logic [1:0]  sel_nxt;
    logic        frame_ld;

    logic [13:0] data_f;
    logic [6:0]  msec_f;
    logic [2:0]  state_f;
    logic        sw_f;

    logic [13:0] data_n;
    logic [6:0]  msec_n;
    logic [2:0]  state_n;
    logic        sw_n;

    logic [13:0] val;
    logic [3:0]  d0, d1, d2, d3;
    logic [3:0]  dig;
    logic        phase_on;
    logic        field_hi;
    logic        field_lo;
    logic [7:0]  seg_nxt;
    logic [3:0]  com_nxt;

    fnd_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign sel_nxt  = sel + 2'd1;
    assign frame_ld = tick && (sel == 2'd3);

    // The digit shown on a frame-load tick must already come from the new sample
    assign data_n  = frame_ld ? i_data           : data_f;
    assign msec_n  = frame_ld ? i_msec           : msec_f;
    assign state_n = frame_ld ? i_watch_state    : state_f;
    assign sw_n    = frame_ld ? i_display_switch : sw_f;

    assign val = sat_9999(data_n);
    assign d0  = 4'(val % 14'd10);
    assign d1  = 4'((val / 14'd10) % 14'd10);
    assign d2  = 4'((val / 14'd100) % 14'd10);
    assign d3  = 4'(val / 14'd1000);

    assign phase_on = (msec_n < 7'd50);
    assign field_hi = ((state_n == ST_SET_HOUR) && !sw_n) ||
                      ((state_n == ST_SET_SEC)  &&  sw_n);
    assign field_lo = (state_n == ST_SET_MIN) && !sw_n;
    assign com_nxt  = sel_to_com(sel_nxt);

    // Segment pattern for the digit that becomes active on the next tick
    always_comb begin
        dig     = d0;
        seg_nxt = SEG_BLANK;
        case (sel_nxt)
            2'd0:    dig = d0;
            2'd1:    dig = d1;
            2'd2:    dig = d2;
            default: dig = d3;
        endcase
        seg_nxt = bcd_to_seg(dig);
        if (!phase_on && ((sel_nxt[1] && field_hi) || (!sel_nxt[1] && field_lo))) begin
            seg_nxt = SEG_BLANK;
        end
`ifdef FND_LEADING_ZERO_BLANK_EN
        if ((sel_nxt == 2'd3) && (d3 == 4'd0)) begin
            seg_nxt = SEG_BLANK;
        end
`else
`endif
        // Centre dp flashes regardless of blanking
        if ((sel_nxt == 2'd2) && phase_on) begin
            seg_nxt[7] = 1'b0;
        end
    end

    // Digit advance, frame latch and registered pin outputs, all on the tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel        <= 2'd0;
            data_f     <= '0;
            msec_f     <= '0;
            state_f    <= '0;
            sw_f       <= 1'b0;
            o_fnd_com  <= COM_OFF;
            o_fnd_data <= SEG_BLANK;
        end else if (tick) begin
            sel        <= sel_nxt;
            o_fnd_com  <= com_nxt;
            o_fnd_data <= seg_nxt;
            if (frame_ld) begin
                data_f  <= i_data;
                msec_f  <= i_msec;
                state_f <= i_watch_state;
                sw_f    <= i_display_switch;
            end
        end
    end

endmodule
